// File: rtl/memory_arbiter_if.sv
// CPU-side request/hit signals and RAM-side strobe/ack signals of the memory arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ack;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ack,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ack,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and LW/SW accesses: data first, fetch after STARVE_MAX data grants.
// Defining MEMARB_IFETCH_BUF_EN adds a one-entry fetch buffer that answers repeat fetches without a RAM access.
module memory_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned WAIT_MAX   = 255
) (
  input logic             CLK,
  input logic             nRST,
  memory_arbiter_if.slave bus
);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {IDLE, IFETCH, DREAD, DWRITE, RECOVER} state_t;

  state_t        state_q;
  logic [SW-1:0] starve_q;
  logic [7:0]    wait_q;
  logic [31:0]   addr_q;
  logic [31:0]   store_q;

  logic strobe, acked, timeout, data_req, fetch_first, buf_hit, dwrite_grant;

  assign strobe       = (state_q == IFETCH) || (state_q == DREAD) || (state_q == DWRITE);
  assign acked        = strobe && bus.ram_ack;
  assign timeout      = strobe && !bus.ram_ack && (wait_q == 8'(WAIT_MAX));
  assign data_req     = bus.dREN || bus.dWEN;
  assign fetch_first  = bus.iREN && (starve_q == SW'(STARVE_MAX));
  assign dwrite_grant = (state_q == IDLE) && bus.dWEN && !fetch_first;

`ifdef MEMARB_IFETCH_BUF_EN
  logic        buf_vld_q;
  logic [31:0] buf_addr_q;
  logic [31:0] buf_dat_q;

  // A buffer hit counts as the fetch grant, so it still yields to pending data.
  assign buf_hit   = (state_q == IDLE) && bus.iREN && buf_vld_q && (bus.iaddr == buf_addr_q) &&
                     (!data_req || fetch_first);
  assign bus.iload = buf_hit ? buf_dat_q : bus.ramload;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_dat_q  <= '0;
    end else if ((state_q == IFETCH) && acked) begin
      buf_vld_q  <= 1'b1;
      buf_addr_q <= addr_q;
      buf_dat_q  <= bus.ramload;
    end else if (dwrite_grant && (bus.daddr == buf_addr_q)) begin
      buf_vld_q <= 1'b0;
    end
  end
`else
  assign buf_hit   = 1'b0;
  assign bus.iload = bus.ramload;
`endif

  // Strobes come from state only; hits and err are masked while reset is asserted.
  assign bus.ramREN   = (state_q == IFETCH) || (state_q == DREAD);
  assign bus.ramWEN   = (state_q == DWRITE);
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.dload    = bus.ramload;
  assign bus.ihit     = nRST && (((state_q == IFETCH) && acked) || buf_hit);
  assign bus.dhit     = nRST && acked && (state_q != IFETCH);
  assign bus.err      = nRST && timeout;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wait_q   <= '0;
      addr_q   <= '0;
      store_q  <= '0;
    end else begin
      if (!bus.iREN) starve_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (buf_hit) begin
            starve_q <= '0;
          end else if (data_req && !fetch_first) begin
            state_q <= bus.dWEN ? DWRITE : DREAD;
            addr_q  <= bus.daddr;
            wait_q  <= '0;
            if (bus.dWEN) store_q <= bus.dstore;
            if (bus.iREN && (starve_q < SW'(STARVE_MAX))) starve_q <= starve_q + 1'b1;
          end else if (bus.iREN) begin
            state_q  <= IFETCH;
            addr_q   <= bus.iaddr;
            wait_q   <= '0;
            starve_q <= '0;
          end
        end
        RECOVER: state_q <= IDLE;
        default: begin
          if (acked || timeout) state_q <= RECOVER;
          else                  wait_q  <= wait_q + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed vector table, hand-written corner sequences, random traffic vs a memory scoreboard.
module tb_memory_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int WAIT_MAX   = 255;

  logic CLK = 1'b0;
  logic nRST;
  memory_arbiter_if bus();

  memory_arbiter #(.STARVE_MAX(STARVE_MAX), .WAIT_MAX(WAIT_MAX)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt(); @(posedge CLK); #1; endtask
  task automatic smp(); @(negedge CLK); endtask

  task automatic clr();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.ram_ack = 0;
  endtask

  // exp bits: {ramREN, ramWEN, ihit, dhit, err}
  typedef struct {
    logic        rst_n, iren;
    logic [31:0] iaddr;
    logic        dren, dwen;
    logic [31:0] daddr;
    logic        ack;
    logic [31:0] rload;
    logic [4:0]  exp;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t mk(logic r, logic i, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                              logic a, logic [31:0] rl, logic [4:0] e, logic [31:0] ea);
    vec_t v;
    v.rst_n = r; v.iren = i; v.iaddr = ia; v.dren = dr; v.dwen = dw; v.daddr = da;
    v.ack = a; v.rload = rl; v.exp = e; v.eaddr = ea;
    return v;
  endfunction

  localparam int NV = 23;
  vec_t vt [NV];

  // Scoreboard state for the random phase.
  logic [31:0] ram_mem [16];
  logic [31:0] ref_mem [16];
  logic        ipend = 0, dpend = 0, prev_strobe = 0, prev_iren = 0, igrant = 0, strobe;
  int          dk = 0, iage = 0, dage = 0, acnt = 0, adly = 0, streak = 0;
  int          n, dgr;
  logic        got;

  initial begin
    vt[0]  = mk(0, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,        5'b00000, 32'h0);
    vt[1]  = mk(0, 1, 32'h40, 1, 1, 32'h100, 1, 32'h0,        5'b00000, 32'h0);
    vt[2]  = mk(1, 1, 32'h40, 0, 0, 32'h0,   0, 32'h0,        5'b00000, 32'h0);
    vt[3]  = mk(1, 1, 32'h40, 0, 0, 32'h0,   0, 32'h0,        5'b10000, 32'h40);
    vt[4]  = mk(1, 1, 32'h40, 0, 0, 32'h0,   0, 32'h0,        5'b10000, 32'h40);
    vt[5]  = mk(1, 1, 32'h40, 0, 0, 32'h0,   0, 32'h0,        5'b10000, 32'h40);
    vt[6]  = mk(1, 1, 32'h40, 0, 0, 32'h0,   1, 32'h3C010001, 5'b10100, 32'h40);
    vt[7]  = mk(1, 0, 32'h40, 0, 0, 32'h0,   0, 32'h0,        5'b00000, 32'h0);
    vt[8]  = mk(1, 1, 32'h44, 1, 0, 32'h100, 0, 32'h0,        5'b00000, 32'h0);
    vt[9]  = mk(1, 1, 32'h44, 1, 0, 32'h100, 0, 32'h0,        5'b10000, 32'h100);
    vt[10] = mk(1, 1, 32'h44, 1, 0, 32'h100, 1, 32'h11111111, 5'b10010, 32'h100);
    vt[11] = mk(1, 1, 32'h44, 0, 0, 32'h0,   0, 32'h0,        5'b00000, 32'h0);
    vt[12] = mk(1, 1, 32'h44, 0, 0, 32'h0,   0, 32'h0,        5'b00000, 32'h0);
    vt[13] = mk(1, 1, 32'h44, 0, 0, 32'h0,   1, 32'h22222222, 5'b10100, 32'h44);
    vt[14] = mk(1, 0, 32'h44, 0, 0, 32'h0,   0, 32'h0,        5'b00000, 32'h0);
    vt[15] = mk(1, 0, 32'h0,  0, 1, 32'h200, 0, 32'h0,        5'b00000, 32'h0);
    vt[16] = mk(1, 0, 32'h0,  0, 1, 32'h200, 0, 32'h0,        5'b01000, 32'h200);
    vt[17] = mk(1, 0, 32'h0,  0, 1, 32'h200, 1, 32'h0,        5'b01010, 32'h200);
    vt[18] = mk(1, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,        5'b00000, 32'h0);
    vt[19] = mk(1, 0, 32'h0,  1, 1, 32'h300, 0, 32'h0,        5'b00000, 32'h0);
    vt[20] = mk(1, 0, 32'h0,  1, 1, 32'h300, 1, 32'h0,        5'b01010, 32'h300);
    vt[21] = mk(1, 0, 32'h0,  0, 0, 32'h0,   0, 32'h0,        5'b00000, 32'h0);
    vt[22] = mk(1, 0, 32'h0,  0, 0, 32'h0,   1, 32'h55,       5'b00000, 32'h0);

    nRST = 0; clr(); bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0; bus.ramload = 0;
    nxt();

    // Directed vectors: fetch with 3-cycle ack, data-over-fetch priority, writes, ignored ack.
    for (int k = 0; k < NV; k++) begin
      nRST = vt[k].rst_n; bus.iREN = vt[k].iren; bus.iaddr = vt[k].iaddr;
      bus.dREN = vt[k].dren; bus.dWEN = vt[k].dwen; bus.daddr = vt[k].daddr;
      bus.dstore = 32'hDEADBEEF; bus.ram_ack = vt[k].ack; bus.ramload = vt[k].rload;
      smp();
      chk($sformatf("vec%0d.outs", k), {27'b0, bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err},
          {27'b0, vt[k].exp});
      if (vt[k].exp[4] || vt[k].exp[3]) chk($sformatf("vec%0d.ramaddr", k), bus.ramaddr, vt[k].eaddr);
      if (vt[k].exp[3]) chk($sformatf("vec%0d.ramstore", k), bus.ramstore, 32'hDEADBEEF);
      if (vt[k].exp[2]) chk($sformatf("vec%0d.iload", k), bus.iload, vt[k].rload);
      if (vt[k].exp[1] && !vt[k].dwen) chk($sformatf("vec%0d.dload", k), bus.dload, vt[k].rload);
      nxt();
    end

    // Starvation guard: data kept requesting, fetch must win after STARVE_MAX data grants.
    clr(); bus.iaddr = 32'h48; bus.daddr = 32'h110; dgr = 0; got = 0;
    for (int c = 0; c < 80 && !got; c++) begin
      bus.iREN = 1; bus.dREN = 1; bus.ram_ack = bus.ramREN | bus.ramWEN;
      smp();
      if (bus.dhit) dgr++;
      if (bus.ihit) got = 1;
      nxt();
    end
    chk("starve.ihit_seen", got, 1);
    chk("starve.data_grants", dgr, STARVE_MAX);
    clr(); smp(); nxt();

    // Timeout: no ack ever, err after WAIT_MAX unacked strobe cycles, then RECOVER, IDLE, retry.
    clr(); bus.dREN = 1; bus.daddr = 32'h500; n = 0; got = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      smp();
      if (bus.err) got = 1;
      else if (bus.ramREN) n++;
      if (bus.dhit) chk("timeout.no_hit", bus.dhit, 0);
      nxt();
    end
    chk("timeout.err_seen", got, 1);
    chk("timeout.strobe_cycles", n, WAIT_MAX);
    smp(); chk("timeout.recover", {29'b0, bus.err, bus.ramREN, bus.dhit}, 0); nxt();
    smp(); chk("timeout.idle", bus.ramREN, 0); nxt();
    bus.ram_ack = 1; bus.ramload = 32'h77;
    smp(); chk("timeout.retry", {30'b0, bus.ramREN, bus.dhit}, 32'h3); nxt();
    clr(); smp(); nxt();

    // Reset mid-DREAD: no hit during reset, strobe gone next cycle, late ack ignored.
    bus.dREN = 1; bus.daddr = 32'h600;
    smp(); nxt();
    smp(); chk("rst.strobe_before", bus.ramREN, 1); nxt();
    nRST = 0; bus.ram_ack = 1; bus.ramload = 32'h99;
    smp(); chk("rst.hits_during", {30'b0, bus.dhit, bus.ihit}, 0); nxt();
    nRST = 1; bus.dREN = 0; bus.ram_ack = 1;
    smp(); chk("rst.after", {27'b0, bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err}, 0); nxt();
    clr();
    smp(); chk("rst.idle", {30'b0, bus.ramREN, bus.ramWEN}, 0); nxt();

`ifdef MEMARB_IFETCH_BUF_EN
    // Fetch buffer: fill, zero-wait repeat hit, invalidate on write to the same address.
    bus.iREN = 1; bus.iaddr = 32'h40;
    smp(); chk("buf.miss_first", bus.ihit, 0); nxt();
    bus.ram_ack = 1; bus.ramload = 32'h0BADF00D;
    smp(); chk("buf.fill_hit", bus.ihit, 1); nxt();
    clr(); smp(); nxt();
    bus.iREN = 1; bus.ramload = 32'h0;
    smp(); chk("buf.hit_now", bus.ihit, 1); chk("buf.hit_data", bus.iload, 32'h0BADF00D); nxt();
    clr(); smp(); chk("buf.no_ram", bus.ramREN, 0); nxt();
    bus.dWEN = 1; bus.daddr = 32'h40; bus.dstore = 32'h1;
    smp(); nxt();
    bus.ram_ack = 1; smp(); nxt();
    clr(); smp(); nxt();
    bus.iREN = 1;
    smp(); chk("buf.invalidated", bus.ihit, 0); nxt();
    bus.ram_ack = 1;
    smp(); chk("buf.refetch", {30'b0, bus.ramREN, bus.ihit}, 32'h3); nxt();
    clr(); smp(); nxt();
`endif

    // Random traffic against a memory scoreboard.
    for (int j = 0; j < 16; j++) begin
      ram_mem[j] = 32'h1000 + j * 32'h01010101;
      ref_mem[j] = ram_mem[j];
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      strobe = bus.ramREN | bus.ramWEN;
      if (strobe) begin
        bus.ram_ack = (acnt == adly);
        bus.ramload = bus.ramREN ? ram_mem[bus.ramaddr[5:2]] : $urandom;
        acnt++;
      end else begin
        acnt = 0; adly = $urandom_range(0, 4);
        bus.ram_ack = ($urandom_range(0, 9) == 0);
        bus.ramload = $urandom;
      end
      if (cyc < 2900) begin
        if (!ipend && $urandom_range(0, 2) == 0) begin
          ipend = 1; iage = 0; bus.iaddr = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
        end
        if (!dpend && $urandom_range(0, 2) == 0) begin
          dpend = 1; dage = 0; dk = $urandom_range(0, 2);
          bus.daddr = {26'b0, 4'($urandom_range(0, 15)), 2'b00}; bus.dstore = $urandom;
        end
      end
      bus.iREN = ipend; bus.dREN = dpend && (dk != 1); bus.dWEN = dpend && (dk != 0);
      smp();
      if (!bus.iREN) streak = 0;
      if (strobe && !prev_strobe) igrant = prev_iren;
      chk("rnd.err", bus.err, 0);
      if (bus.ramWEN)
        chk("rnd.wr_port", dpend && (dk != 0) && bus.ramaddr == bus.daddr && bus.ramstore == bus.dstore, 1);
      if (bus.ramREN)
        chk("rnd.rd_port", (ipend && bus.ramaddr == bus.iaddr) ||
                           (dpend && dk == 0 && bus.ramaddr == bus.daddr), 1);
      if (bus.ram_ack && bus.ramWEN) ram_mem[bus.ramaddr[5:2]] = bus.ramstore;
      if (bus.ihit) begin
        chk("rnd.ihit_req", ipend, 1);
        chk("rnd.iload", bus.iload, ref_mem[bus.iaddr[5:2]]);
        ipend = 0; streak = 0;
      end
      if (bus.dhit) begin
        chk("rnd.dhit_req", dpend, 1);
        if (dk == 0) chk("rnd.dload", bus.dload, ref_mem[bus.daddr[5:2]]);
        else ref_mem[bus.daddr[5:2]] = bus.dstore;
        if (igrant) streak++;
        chk("rnd.starve_bound", streak <= STARVE_MAX, 1);
        dpend = 0;
      end
      if (ipend) iage++;
      if (dpend) dage++;
      if (iage > 150) begin
        checks++; failures++; ipend = 0; iage = 0;
        $display("FAIL rnd.ifetch_wait: fetch pending over 150 cycles, required a hit");
      end
      if (dage > 150) begin
        checks++; failures++; dpend = 0; dage = 0;
        $display("FAIL rnd.data_wait: data access pending over 150 cycles, required a hit");
      end
      prev_strobe = bus.ramREN | bus.ramWEN;
      prev_iren = bus.iREN;
      nxt();
    end
    chk("rnd.drained", {30'b0, ipend, dpend}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
